dct_input_pair_buffer: RTL
==========================

# dct_input_pair_buffer

Upstream feeder for the DCT butterfly stage. Accepts a serial stream of signed samples over a valid/ready handshake and assembles blocks of N samples in a two-bank ping-pong buffer. Each complete block is presented in one beat as N/2 mirrored pairs (x[k], x[N-1-k]) on parallel lanes, ready for N/2 sum/difference butterflies. Sustains one input sample per cycle with no bubbles while the consumer keeps up.

## Interface
- WIDTH, 16, sample width in bits (signed, two's complement)
- N, 8, samples per block; even, power of two, N >= 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  buffer can accept a sample this cycle
- in_data  in  WIDTH  signed input sample
- in_first  in  1  qualifies an accepted sample as index 0 of a new block
- out_valid  out  1  a complete block is presented
- out_ready  in  1  consumer takes the block this cycle
- out_a  out  (N/2)*WIDTH  lane k (bits k*WIDTH +: WIDTH) = x[k]
- out_b  out  (N/2)*WIDTH  lane k = x[N-1-k]
- drop_cnt  out  8  saturating count of partial blocks discarded by in_first

## Operation
- Two banks, each N x WIDTH registers; per-bank state EMPTY, FILLING, FULL.
- Write side: wr_bank, wr_idx (0..N-1). Read side: rd_bank.
- in_ready = (state[wr_bank] != FULL); registered state only, no combinational path from out_ready or in_valid.
- Input accept = in_valid & in_ready.
  - in_first=0: store at wr_idx; bank becomes FILLING; wr_idx increments.
  - in_first=1: store at index 0, wr_idx=1. If bank was FILLING with wr_idx>0, the partial block is discarded and drop_cnt increments (saturates at 255). in_first on a sample that already lands at index 0 does not count as a drop.
  - Sample stored at index N-1 (including in_first with N... not applicable, N>=2): bank becomes FULL, wr_bank toggles, wr_idx=0.
- out_valid = (state[rd_bank] == FULL). out_a/out_b driven from rd_bank registers via the mirrored pair mapping; stable while out_valid & !out_ready.
- Output accept = out_valid & out_ready: state[rd_bank] -> EMPTY, rd_bank toggles.
- Blocks leave strictly in arrival order; no reordering, no arithmetic, no width change.
- Same-cycle input accept and output accept on different banks: both take effect. A bank freed in cycle t is writable from cycle t+1.
- Both banks FULL: in_ready=0 until an output accept.

## Timing
- Reset (rst=1 at a rising edge): both banks EMPTY, all storage 0, wr_bank=rd_bank=0, wr_idx=0, drop_cnt=0. Outputs after reset: in_ready=1, out_valid=0, out_a=out_b=0.
- Reset mid-block or with blocks pending: all data discarded, no output for them, drop_cnt cleared.
- Latency: last sample of a block accepted at edge t -> out_valid=1 after edge t (visible in cycle t+1).
- Throughput: with out_ready held 1, continuous in_valid=1 never sees in_ready=0; one block out every N cycles.
- in_valid ignored while in_ready=0; in_data need not be held across deasserted in_ready beyond normal valid/ready rules.

## Structure
- Shared package dct_pkg: DCT_WIDTH default (16), DCT_N (8), bank-state enum (EMPTY/FILLING/FULL), lane-slice helper constant for k*WIDTH.
- One natural sub-module: dct_pair_bank — N x WIDTH register file with synchronous clear, single write port (index, data, enable), and combinational mirrored-pair read (out_a/out_b lanes). Top instantiates two and owns pointers, states, handshake and drop_cnt.

## Test plan
- Reset then 8 samples 1..8, in_valid=1, out_ready=1 -> in_ready stays 1; out_valid one cycle after sample 8; out_a lanes {1,2,3,4}, out_b lanes {8,7,6,5}.
- 24 back-to-back samples -10..13, out_ready=1 -> three blocks, no in_ready drop, blocks on cycles 9, 17, 25 after first accept, signed values (e.g. -10 / -3 pair) exact.
- out_ready=0 while streaming 20 samples -> in_ready falls after 16 accepted; out_valid held with block 1 stable; raise out_ready for one cycle -> block 1 out, in_ready returns next cycle, block 2 then presented.
- 5 samples, then sample 0x7FFF with in_first=1, then 7 more -> drop_cnt=1; output block starts with 0x7FFF at out_a lane 0.
- in_first=1 on the first sample after reset and on each block boundary -> drop_cnt stays 0; 300 forced drops -> drop_cnt saturates at 255.
- rst asserted after 6 samples with one FULL bank pending -> next cycle out_valid=0, in_ready=1, outputs 0; new 8-sample block emerges normally.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared types and defaults for the DCT input stage.
package dct_pkg;

  localparam int unsigned DCT_WIDTH = 16;
  localparam int unsigned DCT_N     = 8;

  typedef enum logic [1:0] {
    Empty,
    Filling,
    Full
  } bank_state_e;

  // LSB position of lane k in a flattened lane vector.
  function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/dct_pair_bank.sv
// N x Width register file with one write port and a combinational mirrored-pair read.
module dct_pair_bank
  import dct_pkg::*;
#(
  parameter int unsigned Width = DCT_WIDTH,
  parameter int unsigned N     = DCT_N
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(N)-1:0]       wr_idx,
  input  logic [Width-1:0]           wr_data,
  output logic [(N/2)*Width-1:0]     out_a,
  output logic [(N/2)*Width-1:0]     out_b
);

  logic [Width-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Lane k pairs x[k] with x[N-1-k] for the butterfly that follows.
  always_comb begin
    out_a = '0;
    out_b = '0;
    for (int unsigned k = 0; k < N / 2; k++) begin
      out_a[lane_lsb(k, Width) +: Width] = mem_q[k];
      out_b[lane_lsb(k, Width) +: Width] = mem_q[N - 1 - k];
    end
  end

endmodule

// File: rtl/dct_input_pair_buffer.sv
// Ping-pong block assembler: serial samples in, one block of N/2 mirrored pairs out per beat.
module dct_input_pair_buffer
  import dct_pkg::*;
#(
  parameter int unsigned WIDTH = DCT_WIDTH,
  parameter int unsigned N     = DCT_N
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_first,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [(N/2)*WIDTH-1:0]     out_a,
  output logic [(N/2)*WIDTH-1:0]     out_b,
  output logic [7:0]                 drop_cnt
);

  localparam int unsigned IdxW = $clog2(N);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  bank_state_e     state_q [2];
  bank_state_e     state_d [2];
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [IdxW-1:0] wr_idx_q, wr_idx_d;
  logic [7:0]      drop_q, drop_d;

  logic            in_acc, out_acc;
  logic [IdxW-1:0] wr_pos;
  logic [1:0]      bank_we;
  logic [(N/2)*WIDTH-1:0] bank_a [2];
  logic [(N/2)*WIDTH-1:0] bank_b [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0] <= Empty;
      state_q[1] <= Empty;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      drop_q     <= '0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_idx_q   <= wr_idx_d;
      drop_q     <= drop_d;
    end
  end

  // in_first always restarts the block at index 0.
  assign wr_pos = in_first ? '0 : wr_idx_q;

  // An input accept never targets a Full bank and an output accept only targets a Full one,
  // so the two updates below always touch different banks.
  always_comb begin
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_idx_d   = wr_idx_q;
    drop_d     = drop_q;
    if (out_acc) begin
      state_d[rd_bank_q] = Empty;
      rd_bank_d          = ~rd_bank_q;
    end
    if (in_acc) begin
      if (in_first && state_q[wr_bank_q] == Filling && wr_idx_q != '0 && drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
      if (wr_pos == LastIdx) begin
        state_d[wr_bank_q] = Full;
        wr_bank_d          = ~wr_bank_q;
        wr_idx_d           = '0;
      end else begin
        state_d[wr_bank_q] = Filling;
        wr_idx_d           = wr_pos + IdxW'(1);
      end
    end
  end

  always_comb begin
    in_ready   = (state_q[wr_bank_q] != Full);
    out_valid  = (state_q[rd_bank_q] == Full);
    in_acc     = in_valid & in_ready;
    out_acc    = out_valid & out_ready;
    bank_we[0] = in_acc & ~wr_bank_q;
    bank_we[1] = in_acc & wr_bank_q;
    out_a      = bank_a[rd_bank_q];
    out_b      = bank_b[rd_bank_q];
    drop_cnt   = drop_q;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_pair_bank #(
      .Width (WIDTH),
      .N     (N)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bank_we[b]),
      .wr_idx  (wr_pos),
      .wr_data (in_data),
      .out_a   (bank_a[b]),
      .out_b   (bank_b[b])
    );
  end

endmodule
